i2c_config_seq: RTL and testbench

I2C_CONFIG_SEQ -- requirements
Module: i2c_config_seq

---
 rtl/i2c_config_seq.sv | 199 +++++++++++++++++++
 tb/tb_i2c_config_seq.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_config_seq.sv
// I2C configuration sequencer: walks an external register table and issues one
// write request per entry, retrying NACKed entries up to MAX_RETRY attempts.
module i2c_config_seq #(
  parameter int unsigned INIT_DELAY = 1000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [9:0]  lut_size,
  output logic [9:0]  lut_index,
  input  logic [7:0]  lut_dev_addr,
  input  logic [15:0] lut_reg_addr,
  input  logic [7:0]  lut_reg_data,
  input  logic        lut_addr_2byte,
  output logic        i2c_write_req,
  input  logic        i2c_write_req_ack,
  output logic        i2c_read_req,
  output logic [7:0]  i2c_slave_dev_addr,
  output logic [15:0] i2c_slave_reg_addr,
  output logic [7:0]  i2c_write_data,
  output logic        i2c_addr_2byte,
  input  logic        i2c_error,
  output logic        config_done,
  output logic        config_err,
  output logic [1:0]  cur_retry
);

  localparam logic [15:0] LP_DELAY_LAST = (INIT_DELAY > 0) ? 16'(INIT_DELAY - 1) : '0;

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_LOAD,
    S_REQ,
    S_WAIT_ACK,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [15:0] r_delay_cnt;
  logic [9:0]  r_lut_index;
  logic [1:0]  r_retry;
  logic        r_nack;
  logic        r_start_pend;
  logic        r_req;
  logic        r_done;
  logic        r_err;
  logic [7:0]  r_dev_addr;
  logic [15:0] r_reg_addr;
  logic [7:0]  r_wr_data;
  logic        r_addr_2byte;

  logic        w_restart;
  logic        w_set_pend;
  logic        w_ack_take;
  logic        w_load;
  logic        w_index_inc;
  logic        w_retry_inc;
  logic        w_retry_clr;
  logic        w_set_err;
  logic        w_last;
  logic        w_retry_ok;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_INIT_WAIT;
    else     r_state <= w_next_state;
  end

  // Next-state and datapath strobes
  always_comb begin
    w_next_state = r_state;
    w_restart    = 1'b0;
    w_set_pend   = 1'b0;
    w_ack_take   = 1'b0;
    w_load       = 1'b0;
    w_index_inc  = 1'b0;
    w_retry_inc  = 1'b0;
    w_retry_clr  = 1'b0;
    w_set_err    = 1'b0;
    // 11-bit compare also stops at index 1023, so the index never wraps
    w_last       = ({1'b0, r_lut_index} + 11'd1) >= {1'b0, lut_size};
    w_retry_ok   = (32'(r_retry) + 32'd1) < MAX_RETRY;

    case (r_state)
      S_INIT_WAIT: begin
        if (r_delay_cnt == LP_DELAY_LAST)
          w_next_state = (lut_size == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        w_load       = 1'b1;
        w_next_state = S_REQ;
      end
      S_REQ: w_next_state = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (i2c_write_req_ack) begin
          w_ack_take   = 1'b1;
          w_next_state = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!r_nack) begin
          w_retry_clr  = 1'b1;
          w_next_state = S_NEXT;
        end else if (w_retry_ok) begin
          w_retry_inc  = 1'b1;
          w_next_state = S_REQ;
        end else begin
          w_set_err    = 1'b1;
          w_retry_clr  = 1'b1;
          w_next_state = S_NEXT;
        end
      end
      S_NEXT: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_index_inc  = 1'b1;
          w_next_state = S_LOAD;
        end
      end
      S_DONE: w_next_state = S_DONE;
      default: w_next_state = S_INIT_WAIT;
    endcase

    // A restart requested while a transaction is outstanding is deferred to its ack
    if (r_state == S_WAIT_ACK) begin
      if (i2c_write_req_ack && (r_start_pend || cfg_start)) begin
        w_restart    = 1'b1;
        w_next_state = S_INIT_WAIT;
      end else if (cfg_start) begin
        w_set_pend = 1'b1;
      end
    end else if (cfg_start) begin
      w_restart    = 1'b1;
      w_next_state = S_INIT_WAIT;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_delay_cnt  <= '0;
      r_lut_index  <= '0;
      r_retry      <= '0;
      r_nack       <= 1'b0;
      r_start_pend <= 1'b0;
      r_req        <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_dev_addr   <= '0;
      r_reg_addr   <= '0;
      r_wr_data    <= '0;
      r_addr_2byte <= 1'b0;
    end else begin
      r_req  <= (w_next_state == S_REQ) || (w_next_state == S_WAIT_ACK);
      r_done <= (w_next_state == S_DONE);

      if (w_restart || (r_state != S_INIT_WAIT)) r_delay_cnt <= '0;
      else                                       r_delay_cnt <= r_delay_cnt + 16'd1;

      if (w_restart) begin
        r_lut_index  <= '0;
        r_retry      <= '0;
        r_err        <= 1'b0;
        r_start_pend <= 1'b0;
      end else begin
        if (w_set_pend)  r_start_pend <= 1'b1;
        if (w_ack_take)  r_nack <= i2c_error;
        if (w_load) begin
          r_dev_addr   <= lut_dev_addr;
          r_reg_addr   <= lut_reg_addr;
          r_wr_data    <= lut_reg_data;
          r_addr_2byte <= lut_addr_2byte;
        end
        if (w_index_inc) r_lut_index <= r_lut_index + 10'd1;
        if (w_retry_inc)      r_retry <= r_retry + 2'd1;
        else if (w_retry_clr) r_retry <= '0;
        if (w_set_err)   r_err <= 1'b1;
      end
    end
  end

  assign lut_index          = r_lut_index;
  assign i2c_write_req      = r_req;
  assign i2c_read_req       = 1'b0;
  assign i2c_slave_dev_addr = r_dev_addr;
  assign i2c_slave_reg_addr = r_reg_addr;
  assign i2c_write_data     = r_wr_data;
  assign i2c_addr_2byte     = r_addr_2byte;
  assign config_done        = r_done;
  assign config_err         = r_err;
  assign cur_retry          = r_retry;

endmodule

// File: tb/tb_i2c_config_seq.sv
module tb_i2c_config_seq;
  localparam int unsigned INIT_DELAY = 10;
  localparam int unsigned MAX_RETRY  = 3;
  localparam int TBL = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [9:0]  lut_size;
  logic [9:0]  lut_index;
  logic [7:0]  lut_dev_addr;
  logic [15:0] lut_reg_addr;
  logic [7:0]  lut_reg_data;
  logic        lut_addr_2byte;
  logic        i2c_write_req;
  logic        i2c_write_req_ack;
  logic        i2c_read_req;
  logic [7:0]  i2c_slave_dev_addr;
  logic [15:0] i2c_slave_reg_addr;
  logic [7:0]  i2c_write_data;
  logic        i2c_addr_2byte;
  logic        i2c_error;
  logic        config_done;
  logic        config_err;
  logic [1:0]  cur_retry;

  logic [7:0]  tbl_dev [TBL];
  logic [15:0] tbl_reg [TBL];
  logic [7:0]  tbl_dat [TBL];
  logic        tbl_2b  [TBL];

  assign lut_dev_addr   = tbl_dev[lut_index[3:0]];
  assign lut_reg_addr   = tbl_reg[lut_index[3:0]];
  assign lut_reg_data   = tbl_dat[lut_index[3:0]];
  assign lut_addr_2byte = tbl_2b[lut_index[3:0]];

  i2c_config_seq #(.INIT_DELAY(INIT_DELAY), .MAX_RETRY(MAX_RETRY)) dut (
    .clk                (clk),
    .rst                (rst),
    .cfg_start          (cfg_start),
    .lut_size           (lut_size),
    .lut_index          (lut_index),
    .lut_dev_addr       (lut_dev_addr),
    .lut_reg_addr       (lut_reg_addr),
    .lut_reg_data       (lut_reg_data),
    .lut_addr_2byte     (lut_addr_2byte),
    .i2c_write_req      (i2c_write_req),
    .i2c_write_req_ack  (i2c_write_req_ack),
    .i2c_read_req       (i2c_read_req),
    .i2c_slave_dev_addr (i2c_slave_dev_addr),
    .i2c_slave_reg_addr (i2c_slave_reg_addr),
    .i2c_write_data     (i2c_write_data),
    .i2c_addr_2byte     (i2c_addr_2byte),
    .i2c_error          (i2c_error),
    .config_done        (config_done),
    .config_err         (config_err),
    .cur_retry          (cur_retry)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Edge counter and timestamp-based behavioural model
  int  k = 0;
  bit  m_req, m_pend, m_done, m_err, m_rs;
  int  m_req_edge, req_sched = -1, done_sched = -1, err_sched = -1;
  int  m_entry, m_attempt;
  logic [7:0]  s_dev;
  logic [15:0] s_reg;
  logic [7:0]  s_dat;
  logic        s_2b;

  // Stimulus knobs for the master responder
  int  err_mode, err_entry, ack_delay;
  bit  mst_busy;
  int  mst_cnt;

  int  log_idx[$];
  int  log_retry[$];
  int  log_k[$];
  bit  prev_req;
  int  rst_k, done_k;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, k);
    end
  endtask

  function automatic int log_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic model_restart(input int e);
    m_req = 0; m_pend = 0; m_done = 0; m_err = 0;
    m_entry = 0; m_attempt = 0; err_sched = -1;
    if (lut_size == 10'd0) begin
      req_sched = -1; done_sched = e + int'(INIT_DELAY);
    end else begin
      req_sched = e + int'(INIT_DELAY) + 1; done_sched = -1;
    end
  endtask

  task automatic model_outcome(input int e, input logic nack);
    if (nack && (m_attempt + 1 < int'(MAX_RETRY))) begin
      m_attempt++;
      req_sched = e + 1;
    end else begin
      if (nack) err_sched = e + 1;
      m_attempt = 0;
      if (m_entry + 1 >= int'(lut_size)) done_sched = e + 2;
      else begin
        m_entry++;
        req_sched = e + 3;
      end
    end
  endtask

  always @(posedge clk) begin
    k = k + 1;
    m_rs = 0;
    if (rst) begin
      model_restart(k); m_rs = 1;
    end else if (m_req && (k >= m_req_edge + 2)) begin
      if (i2c_write_req_ack) begin
        m_req = 0;
        if (m_pend || cfg_start) begin model_restart(k); m_rs = 1; end
        else model_outcome(k, i2c_error);
      end else if (cfg_start) begin
        m_pend = 1;
      end
    end else if (cfg_start) begin
      model_restart(k); m_rs = 1;
    end
    if (!m_rs) begin
      if (k == req_sched) begin
        m_req = 1; m_req_edge = k; req_sched = -1;
        if (m_attempt == 0) begin
          s_dev = tbl_dev[m_entry % TBL];
          s_reg = tbl_reg[m_entry % TBL];
          s_dat = tbl_dat[m_entry % TBL];
          s_2b  = tbl_2b[m_entry % TBL];
        end
      end
      if (k == done_sched) m_done = 1;
      if (k == err_sched)  m_err  = 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (k >= 1) begin
      chk("write_req", {31'd0, i2c_write_req}, {31'd0, m_req});
      chk("config_done", {31'd0, config_done}, {31'd0, m_done});
      chk("config_err", {31'd0, config_err}, {31'd0, m_err});
      chk("read_req", {31'd0, i2c_read_req}, 32'd0);
      if (m_req) begin
        chk("lut_index", {22'd0, lut_index}, 32'(m_entry));
        chk("cur_retry", {30'd0, cur_retry}, 32'(m_attempt));
        chk("dev_addr", {24'd0, i2c_slave_dev_addr}, {24'd0, s_dev});
        chk("reg_addr", {16'd0, i2c_slave_reg_addr}, {16'd0, s_reg});
        chk("wr_data", {24'd0, i2c_write_data}, {24'd0, s_dat});
        chk("addr_2byte", {31'd0, i2c_addr_2byte}, {31'd0, s_2b});
      end
      if (i2c_write_req === 1'b1 && !prev_req) begin
        log_idx.push_back(int'(lut_index));
        log_retry.push_back(int'(cur_retry));
        log_k.push_back(k);
      end
      prev_req = (i2c_write_req === 1'b1);
    end
  end

  function automatic bit plan_err();
    case (err_mode)
      0: return 1'b0;
      1: return (m_entry == err_entry);
      2: return (m_entry == err_entry) && (m_attempt == 0);
      default: return ($urandom_range(0, 2) == 0);
    endcase
  endfunction

  // I2C master responder; also scrambles the table entry under an outstanding request
  initial begin
    i2c_write_req_ack = 1'b0;
    i2c_error = 1'b0;
    forever begin
      @(negedge clk);
      i2c_write_req_ack = 1'b0;
      i2c_error = 1'b0;
      if (mst_busy) begin
        tbl_dev[m_entry % TBL] = 8'($urandom);
        tbl_dat[m_entry % TBL] = 8'($urandom);
        mst_cnt--;
        if (mst_cnt <= 0) begin
          i2c_write_req_ack = 1'b1;
          i2c_error = plan_err();
          mst_busy = 0;
        end
      end else if (i2c_write_req === 1'b1) begin
        mst_busy = 1;
        mst_cnt = (ack_delay > 0) ? ack_delay : int'($urandom_range(1, 6));
      end
    end
  end

  task automatic fill_table();
    for (int i = 0; i < TBL; i++) begin
      tbl_dev[i] = 8'($urandom);
      tbl_reg[i] = 16'($urandom);
      tbl_dat[i] = 8'($urandom);
      tbl_2b[i]  = 1'($urandom);
    end
  endtask

  task automatic start_run(input int size, input int emode, input int eentry, input int dly);
    @(negedge clk);
    lut_size = 10'(size);
    err_mode = emode; err_entry = eentry; ack_delay = dly;
    fill_table();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rst_k = k;
    mst_busy = 0;
    log_idx.delete(); log_retry.delete(); log_k.delete();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (config_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    done_k = k;
    chk("done_reached", {31'd0, config_done}, 32'd1);
  endtask

  task automatic wait_log(input int cnt, input int budget);
    int n = 0;
    while (log_idx.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("log_reached", 32'(log_idx.size() >= cnt), 32'd1);
  endtask

  int exp35_i[5] = '{0, 1, 1, 1, 2};
  int exp35_r[5] = '{0, 0, 1, 2, 0};
  int exp36_i[4] = '{0, 0, 1, 2};
  int exp36_r[4] = '{0, 1, 0, 0};
  int pulses, n;

  initial begin
    rst = 1'b1; cfg_start = 1'b0; lut_size = 10'd3;
    err_mode = 0; err_entry = 0; ack_delay = 5; mst_busy = 0;
    fill_table();
    repeat (2) @(negedge clk);
    chk("rst_index", {22'd0, lut_index}, 32'd0);
    chk("rst_dev", {24'd0, i2c_slave_dev_addr}, 32'd0);
    chk("rst_reg", {16'd0, i2c_slave_reg_addr}, 32'd0);
    chk("rst_data", {24'd0, i2c_write_data}, 32'd0);
    chk("rst_2byte", {31'd0, i2c_addr_2byte}, 32'd0);
    chk("rst_retry", {30'd0, cur_retry}, 32'd0);

    // Three clean entries, ack five cycles after each request
    start_run(3, 0, 0, 5);
    wait_done(400);
    chk("t1_nreq", 32'(log_idx.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("t1_order", 32'(log_at(log_idx, i)), 32'(i));
    chk("t1_first_req", 32'(log_at(log_k, 0) - rst_k), 32'd11);
    chk("t1_gap", 32'(log_at(log_k, 1) - log_at(log_k, 0)), 32'd9);
    chk("t1_done_edge", 32'(done_k - log_at(log_k, 2)), 32'd8);
    chk("t1_err", {31'd0, config_err}, 32'd0);

    // Entry 1 always NACKed: exhausts its retries
    start_run(3, 1, 1, 5);
    wait_done(600);
    chk("t2_nreq", 32'(log_idx.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t2_idx", 32'(log_at(log_idx, i)), 32'(exp35_i[i]));
      chk("t2_retry", 32'(log_at(log_retry, i)), 32'(exp35_r[i]));
    end
    chk("t2_err", {31'd0, config_err}, 32'd1);

    // Entry 0 NACKed once, then accepted
    start_run(3, 2, 0, 3);
    wait_done(600);
    chk("t3_nreq", 32'(log_idx.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_idx", 32'(log_at(log_idx, i)), 32'(exp36_i[i]));
      chk("t3_retry", 32'(log_at(log_retry, i)), 32'(exp36_r[i]));
    end
    chk("t3_err", {31'd0, config_err}, 32'd0);

    // Empty table
    start_run(0, 0, 0, 5);
    wait_done(100);
    chk("t4_done_edge", 32'(done_k - rst_k), 32'd10);
    repeat (20) @(negedge clk);
    chk("t4_nreq", 32'(log_idx.size()), 32'd0);

    // cfg_start while waiting for an ack
    start_run(4, 1, 0, 8);
    wait_log(4, 600);
    repeat (3) @(negedge clk);
    chk("t5_err_before", {31'd0, config_err}, 32'd1);
    err_mode = 0;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    @(negedge clk);
    chk("t5_hold_req", {31'd0, i2c_write_req}, 32'd1);
    wait_log(5, 100);
    chk("t5_restart_idx", 32'(log_at(log_idx, 4)), 32'd0);
    chk("t5_restart_err", {31'd0, config_err}, 32'd0);
    wait_done(600);
    chk("t5_err_final", {31'd0, config_err}, 32'd0);

    // Reset pulse mid-sequence at index 5
    start_run(8, 0, 0, 2);
    n = 0;
    while (lut_index !== 10'd5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach5", {22'd0, lut_index}, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rst_k = k;
    log_idx.delete(); log_retry.delete(); log_k.delete();
    chk("t6_index", {22'd0, lut_index}, 32'd0);
    chk("t6_req", {31'd0, i2c_write_req}, 32'd0);
    wait_done(600);
    chk("t6_first_req", 32'(log_at(log_k, 0) - rst_k), 32'd11);
    chk("t6_first_idx", 32'(log_at(log_idx, 0)), 32'd0);

    // Randomized runs with random NACKs, ack delays and restart pulses
    for (int it = 0; it < 8; it++) begin
      start_run(int'($urandom_range(1, TBL)), 3, 0, 0);
      pulses = 0;
      n = 0;
      while (config_done !== 1'b1 && n < 3000) begin
        @(negedge clk);
        n++;
        if (pulses < 2 && $urandom_range(0, 60) == 0) begin
          cfg_start = 1'b1;
          pulses++;
          @(negedge clk);
          cfg_start = 1'b0;
          n++;
        end
      end
      chk("rand_done", {31'd0, config_done}, 32'd1);
      if (it % 2 == 1) begin
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        @(negedge clk);
        wait_done(3000);
      end
      repeat (5) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
